// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg: definitions shared by the DDR lane front-end.
//   lane_t       2-bit lane index (L=0, U=1, D=2, R=3)
//   arb_state_e  press arbiter state
//   rr_pick      round-robin pick of the first pending lane after 'last'
//   count_ones   population count of a per-lane bit vector
// ---------------------------------------------------------------------------
package ddr_pkg;

  localparam int unsigned NUM_LANES = 4;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_L = 2'd0;
  localparam lane_t LANE_U = 2'd1;
  localparam lane_t LANE_D = 2'd2;
  localparam lane_t LANE_R = 2'd3;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

  // Search (last+1) mod 4 upward with wrap. Walk the distance downward so the
  // nearest pending lane overwrites the result last. With nothing pending,
  // 'last' is returned and is ignored by the caller.
  function automatic lane_t rr_pick(input logic [NUM_LANES-1:0] pend, input lane_t last);
    lane_t idx;
    rr_pick = last;
    for (int i = NUM_LANES; i >= 1; i--) begin
      idx = last + lane_t'(i);
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [2:0] count_ones(input logic [NUM_LANES-1:0] v);
    count_ones = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      count_ones = count_ones + {2'b00, v[i]};
    end
  endfunction

endpackage

// File: rtl/lane_debounce.sv
// ---------------------------------------------------------------------------
// lane_debounce: one raw button -> one-cycle press pulse.
//   2-FF synchroniser, stability counter, rising-edge detect of the debounced
//   level. Release produces no pulse.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   i_btn    raw asynchronous button level
//   o_press  registered 1-cycle pulse on a debounced 0->1 transition
// ---------------------------------------------------------------------------
module lane_debounce
  import ddr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned CNT_W        = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  logic             w_differ;
  logic             w_flip;

  // The counter value DEB_LAST plus this cycle's increment reaches DEBOUNCE_CYC.
  always_comb begin
    w_differ = (r_sync2 != r_deb);
    w_flip   = w_differ && (r_cnt == DEB_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (w_flip) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      r_press <= w_flip && r_sync2;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/lane_press_ctrl.sv
// ---------------------------------------------------------------------------
// lane_press_ctrl: front end for the four DDR lanes (L, U, D, R).
//   Debounces each button, lights the lane for LIT_CYC cycles per press
//   (retriggerable), and arbitrates pending presses round-robin into one
//   valid/ready event stream.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   btnL/U/D/R        raw buttons, lanes 0..3
//   lane_lit[3:0]     lane i lit (to player-bar renderer)
//   press_valid       event offered to scorer
//   press_lane[1:0]   lane of offered event, stable while press_valid
//   press_ready       scorer accepts when press_valid && press_ready
//   drop_count[7:0]   saturating drop counter (only with DROP_CNT_EN)
// Build option: define DROP_CNT_EN to add the drop_count port and counter.
// ---------------------------------------------------------------------------
module lane_press_ctrl
  import ddr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned LIT_CYC      = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnL,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnR,
  output logic [3:0] lane_lit,
  output logic       press_valid,
  output logic [1:0] press_lane,
  input  logic       press_ready
`ifdef DROP_CNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int unsigned MAX_CYC = (DEBOUNCE_CYC > LIT_CYC) ? DEBOUNCE_CYC : LIT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] LIT_LOAD = CNT_W'(LIT_CYC);

  logic [NUM_LANES-1:0] w_btn;
  logic [NUM_LANES-1:0] w_press;

  assign w_btn = {btnR, btnD, btnU, btnL};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (w_btn[g]),
      .o_press (w_press[g])
    );
  end

  // -------------------------------------------------------------------------
  // Lit timers
  // -------------------------------------------------------------------------
  logic [NUM_LANES-1:0][CNT_W-1:0] r_timer;
  logic [NUM_LANES-1:0][CNT_W-1:0] w_timer_d;
  logic [NUM_LANES-1:0]            r_lit;
  logic [NUM_LANES-1:0]            w_lit_d;

  always_comb begin
    w_timer_d = r_timer;
    w_lit_d   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_press[i]) begin
        w_timer_d[i] = LIT_LOAD;
      end else if (r_timer[i] != '0) begin
        w_timer_d[i] = r_timer[i] - 1'b1;
      end else begin
        w_timer_d[i] = '0;
      end
      // Registering the flag from the next timer value keeps it aligned with
      // the timer itself while driving the output straight from a flop.
      w_lit_d[i] = (w_timer_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_lit   <= '0;
    end else begin
      r_timer <= w_timer_d;
      r_lit   <= w_lit_d;
    end
  end

  assign lane_lit = r_lit;

  // -------------------------------------------------------------------------
  // Pending bits and drops
  // -------------------------------------------------------------------------
  arb_state_e           r_state;
  arb_state_e           w_state_d;
  lane_t                r_lane;
  lane_t                w_lane_d;
  lane_t                r_last;
  lane_t                w_last_d;
  logic [NUM_LANES-1:0] r_pend;
  logic [NUM_LANES-1:0] w_pend_d;
  logic [NUM_LANES-1:0] w_clr;
  logic [NUM_LANES-1:0] w_drop;
  logic                 w_accept;

  assign w_accept = (r_state == ARB_OFFER) && press_ready;

  // Set wins over clear: a press landing on the accepted lane re-arms it and
  // is not a drop.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_clr[i] = w_accept && (r_lane == lane_t'(i));
    end
    w_pend_d = w_press | (r_pend & ~w_clr);
    w_drop   = w_press & r_pend & ~w_clr;
  end

  // -------------------------------------------------------------------------
  // Arbiter
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    w_lane_d  = r_lane;
    w_last_d  = r_last;
    case (r_state)
      ARB_IDLE: begin
        if (|r_pend) begin
          w_lane_d  = rr_pick(r_pend, r_last);
          w_state_d = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        // Offer is held until taken; new presses only queue up.
        if (press_ready) begin
          w_last_d  = r_lane;
          w_state_d = ARB_IDLE;
        end
      end
      default: w_state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_lane  <= LANE_L;
      r_last  <= LANE_R;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_d;
      r_lane  <= w_lane_d;
      r_last  <= w_last_d;
      r_pend  <= w_pend_d;
    end
  end

  assign press_valid = (r_state == ARB_OFFER);
  assign press_lane  = r_lane;

  // -------------------------------------------------------------------------
  // Optional drop counter
  // -------------------------------------------------------------------------
`ifdef DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic [8:0] w_drop_sum;

  always_comb begin
    w_drop_sum = {1'b0, r_drop_cnt} + {6'd0, count_ones(w_drop)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign drop_count = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = |w_drop;
`endif

endmodule

// File: tb/tb_lane_press_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lane_press_ctrl: directed bench for lane_press_ctrl with
// DEBOUNCE_CYC=4, LIT_CYC=10. drop_count checks apply when DROP_CNT_EN is
// defined for the build.
// Step convention: inputs change 1 time unit after a rising edge P(k-1);
// the value set in step k is captured at edge P(k); outputs are read 1 time
// unit after P(k).
// ---------------------------------------------------------------------------
module tb_lane_press_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned LIT = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnL, btnU, btnD, btnR;
  logic [3:0] lane_lit;
  logic       press_valid;
  logic [1:0] press_lane;
  logic       press_ready;
`ifdef DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] ev_q[$];

  always #5 clk = ~clk;

  lane_press_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .LIT_CYC      (LIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btnL        (btnL),
    .btnU        (btnU),
    .btnD        (btnD),
    .btnR        (btnR),
    .lane_lit    (lane_lit),
    .press_valid (press_valid),
    .press_lane  (press_lane),
    .press_ready (press_ready)
`ifdef DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  // Record every accepted event; ready/valid are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n && press_valid && press_ready) ev_q.push_back(press_lane);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btnR, btnD, btnU, btnL} = m;
  endtask

  function automatic logic [31:0] get_ev(input int i);
    if (i < ev_q.size()) return {30'd0, ev_q[i]};
    return 32'd7;
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    press_ready = 1'b0;
    set_btns(4'b0000);
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic wait_valid(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (press_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int   cnt;
    int   first;
    int   last;
    int   bad;
    logic ok;

    rst_n       = 1'b0;
    press_ready = 1'b0;
    set_btns(4'b0000);
    #12;
    check_eq("rst_valid", press_valid, 0);
    check_eq("rst_lit", lane_lit, 0);
    check_eq("rst_lane", press_lane, 0);
`ifdef DROP_CNT_EN
    check_eq("rst_drop", drop_count, 0);
`endif
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Glitch: btnU high 3 cycles is shorter than the debounce window.
    press_ready = 1'b1;
    ev_q.delete();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      set_btns((k < 3) ? 4'b0010 : 4'b0000);
      tick(1);
      if (lane_lit != 4'd0) cnt++;
    end
    check_eq("glitch_events", ev_q.size(), 0);
    check_eq("glitch_lit_cycles", cnt, 0);

    // Clean press: btnU held 8 cycles.
    ev_q.delete();
    cnt   = 0;
    first = -1;
    for (int k = 0; k < 30; k++) begin
      set_btns((k < 8) ? 4'b0010 : 4'b0000);
      tick(1);
      if (lane_lit[1]) cnt++;
      if (press_valid && first < 0) first = k;
    end
    check_eq("press_events", ev_q.size(), 1);
    check_eq("press_lane_u", get_ev(0), 1);
    check_eq("press_lit_cycles", cnt, LIT);
    check_eq("press_latency_ok", (first >= 6 && first <= 8), 1);
    check_eq("press_lit_off", lane_lit, 0);

    // Retrigger: pulses after P5 and P13; lit continuous from P6 to P23.
    ev_q.delete();
    cnt   = 0;
    first = -1;
    last  = -1;
    for (int k = 0; k < 40; k++) begin
      set_btns(((k < 4) || (k >= 8 && k < 12)) ? 4'b0001 : 4'b0000);
      tick(1);
      if (lane_lit[0]) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check_eq("retrig_first", first, 6);
    check_eq("retrig_last", last, 23);
    check_eq("retrig_cnt", cnt, 18);
    check_eq("retrig_events", ev_q.size(), 2);

    // Round-robin from reset: last_grant=3, lane 0 first.
    do_reset();
    press_ready = 1'b1;
    ev_q.delete();
    set_btns(4'b1111);
    tick(6);
    set_btns(4'b0000);
    tick(25);
    check_eq("rr4_count", ev_q.size(), 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("rr4_ev%0d", i), get_ev(i), i);

    ev_q.delete();
    set_btns(4'b0101);
    tick(6);
    set_btns(4'b0000);
    tick(20);
    check_eq("rr2_count", ev_q.size(), 2);
    check_eq("rr2_ev0", get_ev(0), 0);
    check_eq("rr2_ev1", get_ev(1), 2);

    // Backpressure on lane 2.
    press_ready = 1'b0;
    ev_q.delete();
    set_btns(4'b0100);
    tick(4);
    set_btns(4'b0000);
    wait_valid(20, ok);
    check_eq("bp_valid_seen", ok, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!press_valid || press_lane != 2'd2) bad++;
    end
    check_eq("bp_hold_bad", bad, 0);
    check_eq("bp_lane", press_lane, 2);
    press_ready = 1'b1;
    tick(1);
    check_eq("bp_valid_drop", press_valid, 0);
    press_ready = 1'b0;
    check_eq("bp_events", ev_q.size(), 1);
    check_eq("bp_ev_lane", get_ev(0), 2);
    tick(4);

    // Drops: three lane-3 presses with the scorer stalled.
    ev_q.delete();
    for (int p = 0; p < 3; p++) begin
      set_btns(4'b1000);
      tick(4);
      set_btns(4'b0000);
      tick(8);
    end
    check_eq("drop_valid", press_valid, 1);
    check_eq("drop_lane", press_lane, 3);
`ifdef DROP_CNT_EN
    check_eq("drop_count2", drop_count, 2);
`endif

    // Press pulse after P5 meets acceptance at P6: set wins, no drop.
    for (int k = 0; k < 8; k++) begin
      set_btns((k < 4) ? 4'b1000 : 4'b0000);
      press_ready = (k == 6);
      tick(1);
    end
    press_ready = 1'b0;
    tick(2);
    check_eq("setwin_events", ev_q.size(), 1);
    check_eq("setwin_reoffer", press_valid, 1);
    check_eq("setwin_lane", press_lane, 3);
`ifdef DROP_CNT_EN
    check_eq("setwin_drop", drop_count, 2);
`endif
    press_ready = 1'b1;
    tick(2);
    press_ready = 1'b0;
    check_eq("setwin_events2", ev_q.size(), 2);
    tick(4);

    // Reset mid-offer with btnR held through release.
    ev_q.delete();
    set_btns(4'b0010);
    tick(4);
    set_btns(4'b0000);
    wait_valid(20, ok);
    check_eq("rmo_valid_seen", ok, 1);
    set_btns(4'b1000);
    tick(2);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rmo_valid", press_valid, 0);
    check_eq("rmo_lit", lane_lit, 0);
`ifdef DROP_CNT_EN
    check_eq("rmo_drop", drop_count, 0);
`endif
    tick(3);
    rst_n       = 1'b1;
    press_ready = 1'b1;
    ok          = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (ev_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("rmo_event_seen", ok, 1);
    check_eq("rmo_ev_lane", get_ev(0), 3);
    set_btns(4'b0000);
    tick(20);
    check_eq("rmo_events", ev_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lane_press_ctrl.md
Name: lane_press_ctrl

Overview:
Front-end controller for the four DDR lanes (L, U, D, R). It synchronises and debounces the raw buttons and turns each clean press into a one-shot event. It drives the per-lane "lit" flags that the player-bar renderer uses to fill a column. It also arbitrates simultaneous presses round-robin into a single valid/ready event stream for the judgement/scoring logic.

Parameters:
DEBOUNCE_CYC, 1000000, consecutive stable cycles (10 ms at 100 MHz) before a debounced level changes; must be >= 1
LIT_CYC, 25000000, cycles a lane stays lit after a press; must be >= 1
CNT_W, $clog2(max(DEBOUNCE_CYC,LIT_CYC)+1), counter width (derived, not overridden)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
btnL  in  1  raw button, lane 0, asynchronous
btnU  in  1  raw button, lane 1, asynchronous
btnD  in  1  raw button, lane 2, asynchronous
btnR  in  1  raw button, lane 3, asynchronous
lane_lit  out  4  bit i high while lane i is lit (to player-bar renderer)
press_valid  out  1  press event offered to scorer
press_lane  out  2  lane index of offered event; stable while press_valid=1
press_ready  in  1  scorer accepts the event when press_valid && press_ready
drop_count  out  8  only when DROP_CNT_EN is defined (see Optional Feature)

Behaviour:
- Reset values: lane_lit=0, press_valid=0, press_lane=0, all sync FFs/debounced levels/counters/pending bits=0, last_grant=3, so lane 0 has first priority.
- Input path, per lane:
  - 2-FF synchroniser, then debounce.
  - If the synced level differs from the debounced level, the counter increments. Otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYC, the debounced level flips and the counter clears.
  - A debounced 0->1 transition produces a 1-cycle press pulse.
  - Latency from a stable raw edge to the press pulse is DEBOUNCE_CYC+2 cycles (within +/-1 for sync alignment).
  - Release produces no event.
- Lit timer, per lane:
  - A press pulse loads LIT_CYC. The timer decrements while nonzero.
  - lane_lit[i] = (timer_i != 0), registered.
  - A press while lit reloads the timer to LIT_CYC (retrigger).
- Pending, per lane:
  - A press pulse sets pending[i].
  - A press arriving while pending[i]=1 and not being accepted that cycle is a drop; the pending bit stays 1.
  - If a press and an acceptance of the same lane occur in the same cycle, set wins: pending stays 1 and no drop is counted.
- Arbiter FSM:
  - IDLE:
    - If any pending bit is set, select the first pending lane searching (last_grant+1) mod 4 upward with wrap.
    - Register press_lane, set press_valid=1, go to OFFER.
    - Otherwise stay in IDLE.
  - OFFER:
    - press_valid and press_lane are held stable.
    - On press_ready=1: clear pending[press_lane] (subject to the set-wins rule), set last_grant=press_lane, press_valid=0 next cycle, go to IDLE.
    - A press of a different lane during OFFER only sets its pending bit; it never preempts the offer.
  - Throughput: at most one event per 2 cycles; the scorer sees events in round-robin order.
- Reset mid-operation:
  - Asynchronous assertion immediately clears everything to reset values, including any offered event, which is lost.
  - A button held through reset release is debounced as a fresh press.

Optional Feature:
DROP_CNT_EN
- Defined: the drop_count port exists. It is an 8-bit counter that increments once per drop cycle, saturates at 255, and is cleared only by rst_n.
- If 2 or more lanes drop in the same cycle, it increments by the number of dropping lanes (saturating).
- Undefined: the port and counter are absent; drops are silent.

Decomposition:
- Shared package ddr_pkg:
  - lane_t (2-bit lane index)
  - LANE_L=0, LANE_U=1, LANE_D=2, LANE_R=3
  - NUM_LANES=4
  - arbiter state enum {ARB_IDLE, ARB_OFFER}
- Sub-module lane_debounce (synchroniser, debounce counter, edge detect; output press pulse), instantiated 4x.
- Lit timers, pending bits and the arbiter stay in lane_press_ctrl.

Test Plan:
(All scenarios use DEBOUNCE_CYC=4, LIT_CYC=10, DROP_CNT_EN defined.)
- Debounce:
  - btnU raised for 3 cycles, then low -> no event, lane_lit=0.
  - Raised and held 8 cycles -> exactly one event with press_lane=1, and lane_lit[1]=1 for exactly 10 cycles.
- Retrigger: btnL press, release, press again 6 cycles after the first lit -> lane_lit[0] stays high continuously until 10 cycles after the second press.
- Round-robin: all four buttons pressed in the same cycle, press_ready=1 -> events in lane order 0,1,2,3. Then pressing lanes 0 and 2 together -> order 0,2.
- Backpressure: btnD press with press_ready=0 for 20 cycles -> press_valid=1 with press_lane=2 held stable. press_ready=1 -> accepted, press_valid=0 next cycle.
- Drop/saturation:
  - With press_ready=0, lane 3 pressed 3 times -> one event, drop_count=2.
  - Same-cycle press of lane 3 and its acceptance -> a second event follows, drop_count unchanged.
- Reset mid-offer: rst_n low during OFFER -> press_valid, lane_lit, drop_count all 0 asynchronously. After release with btnR held -> one new event for lane 3 after debounce.
